// File: rtl/float_mul_if.sv
`default_nettype none
// ============================================================================
// Module   : float_mul_if
// Purpose  : Start/valid handshake bundle for the single-precision multiplier.
//            The requester (master) drives start and the two operands. The
//            multiplier (slave) returns busy, a one-cycle valid pulse and the
//            held product.
// Signals  : start   - one-cycle request, master -> slave
//            X, Y    - IEEE-754 single operands, master -> slave
//            busy    - operation in progress, slave -> master
//            valid   - one-cycle result strobe, slave -> master
//            product - IEEE-754 single result, slave -> master
// Revision : 1.0 - initial release
// ============================================================================
interface float_mul_if;
  logic        start;
  logic [31:0] X;
  logic [31:0] Y;
  logic        busy;
  logic        valid;
  logic [31:0] product;

  modport master (output start, X, Y, input busy, valid, product);
  modport slave  (input start, X, Y, output busy, valid, product);
endinterface
`default_nettype wire

// File: rtl/float_mul.sv
`default_nettype none
// ============================================================================
// Module   : float_mul
// Purpose  : Multi-cycle IEEE-754 single-precision multiplier. The mantissa
//            product is built by an iterative shift-add, one multiplier bit
//            per cycle, so latency is fixed for every operand pair: valid
//            rises 27 edges after the accepting edge.
// Ports    : clk  - clock, rising edge
//            rst  - synchronous active-high reset (aborts any operation)
//            bus  - float_mul_if.slave (start, X, Y, busy, valid, product)
// Config   : FLOAT_MUL_RNE_EN defined   -> round to nearest, ties to even
//            FLOAT_MUL_RNE_EN undefined -> truncation (same latency)
// Revision : 1.0 - initial release
// ============================================================================
module float_mul #(
  parameter int MANT_W = 24,
  parameter int BIAS   = 127
) (
  input  logic           clk,
  input  logic           rst,
  float_mul_if.slave     bus
);

  localparam logic [4:0]        LAST_BIT = 5'(MANT_W - 1);
  localparam logic signed [9:0] E_BIAS   = 10'(BIAS);
  localparam logic signed [9:0] E_MAX    = 10'sd255;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    UNPACK = 3'd1,
    MULT   = 3'd2,
    NORM   = 3'd3,
    ROUND  = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t state, state_nx;

  logic [31:0]       x_q, y_q;
  logic              sign;
  logic signed [9:0] e;
  logic [47:0]       mcand;    // multiplicand, shifted left each iteration
  logic [23:0]       mplier;   // multiplier, consumed LSB first
  logic [47:0]       acc;
  logic [4:0]        counter;
  logic [22:0]       mant;
  logic              guard, sticky;
  logic              res_nan, res_inf, res_zero;
  logic [31:0]       product_q;
  logic              valid_q;

  // Operand classification from the latched operands
  logic [7:0]  ex, ey;
  logic        x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
  assign ex     = x_q[30:23];
  assign ey     = y_q[30:23];
  assign x_zero = (ex == 8'h00);   // denormals flushed to zero
  assign y_zero = (ey == 8'h00);
  assign x_inf  = (ex == 8'hFF) && (x_q[22:0] == 23'h0);
  assign y_inf  = (ey == 8'hFF) && (y_q[22:0] == 23'h0);
  assign x_nan  = (ex == 8'hFF) && (x_q[22:0] != 23'h0);
  assign y_nan  = (ey == 8'hFF) && (y_q[22:0] != 23'h0);

  // Rounding and result resolution, consumed on the ROUND edge
  logic              round_inc;
  logic [23:0]       mant_rnd;   // [23] is the carry out of the fraction
  logic signed [9:0] e_rnd;
  logic [31:0]       result;

`ifdef FLOAT_MUL_RNE_EN
  assign round_inc = guard & (sticky | mant[0]);
`else
  logic unused_grs;
  assign unused_grs = guard | sticky;
  assign round_inc  = 1'b0;
`endif

  assign mant_rnd = {1'b0, mant} + {23'h0, round_inc};
  assign e_rnd    = e + (mant_rnd[23] ? 10'sd1 : 10'sd0);

  always_comb begin
    result = {sign, e_rnd[7:0], mant_rnd[22:0]};
    if (res_nan)             result = 32'h7FC00000;
    else if (res_inf)        result = {sign, 8'hFF, 23'h0};
    else if (res_zero)       result = {sign, 31'h0};
    else if (e_rnd >= E_MAX) result = {sign, 8'hFF, 23'h0};
    else if (e_rnd <= 10'sd0) result = {sign, 31'h0};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = UNPACK;
      UNPACK:  state_nx = MULT;
      MULT:    if (counter == LAST_BIT) state_nx = NORM;
      NORM:    state_nx = ROUND;
      ROUND:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q       <= 32'h0;
      y_q       <= 32'h0;
      sign      <= 1'b0;
      e         <= 10'sd0;
      mcand     <= 48'h0;
      mplier    <= 24'h0;
      acc       <= 48'h0;
      counter   <= 5'd0;
      mant      <= 23'h0;
      guard     <= 1'b0;
      sticky    <= 1'b0;
      res_nan   <= 1'b0;
      res_inf   <= 1'b0;
      res_zero  <= 1'b0;
      product_q <= 32'h0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            x_q <= bus.X;
            y_q <= bus.Y;
          end
        end
        UNPACK: begin
          sign     <= x_q[31] ^ y_q[31];
          e        <= $signed({2'b00, ex}) + $signed({2'b00, ey}) - E_BIAS;
          mcand    <= {24'h0, ~x_zero, x_q[22:0]};
          mplier   <= {~y_zero, y_q[22:0]};
          acc      <= 48'h0;
          counter  <= 5'd0;
          // Inf*0 is invalid and therefore joins the NaN class
          res_nan  <= x_nan | y_nan | (x_inf & y_zero) | (y_inf & x_zero);
          res_inf  <= x_inf | y_inf;
          res_zero <= x_zero | y_zero;
        end
        MULT: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          counter <= counter + 5'd1;
        end
        NORM: begin
          // Product of two 1.x mantissas lies in [1,4): bit 47 set means >= 2
          if (acc[47]) begin
            mant   <= acc[46:24];
            guard  <= acc[23];
            sticky <= |acc[22:0];
            e      <= e + 10'sd1;
          end else begin
            mant   <= acc[45:23];
            guard  <= acc[22];
            sticky <= |acc[21:0];
          end
        end
        ROUND: begin
          product_q <= result;
          valid_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state == UNPACK) || (state == MULT) ||
                       (state == NORM)   || (state == ROUND);
  assign bus.valid   = valid_q;
  assign bus.product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_float_mul.sv
`default_nettype none
// ============================================================================
// Module   : tb_float_mul
// Purpose  : Self-checking bench for float_mul. A field-level reference model
//            predicts every product; a per-cycle compare process checks
//            valid/busy/product against a cycle-age tracker; directed
//            vectors pin the model with hand-computed literals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_float_mul;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  float_mul_if bus ();
  float_mul dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference: exact integer product of the mantissas, then normalise,
  // round and classify directly from IEEE-754 rules.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    int ea, eb, e, sh;
    longint unsigned ma, mb, p, mant;
    bit na, nb, ia, ib, za, zb;
`ifdef FLOAT_MUL_RNE_EN
    longint unsigned rem, half;
`endif
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    na = (ea == 255) && (a[22:0] != 0);
    nb = (eb == 255) && (b[22:0] != 0);
    ia = (ea == 255) && (a[22:0] == 0);
    ib = (eb == 255) && (b[22:0] == 0);
    za = (ea == 0);
    zb = (eb == 0);
    if (na || nb || (ia && zb) || (ib && za)) return 32'h7FC00000;
    if (ia || ib) return {s, 8'hFF, 23'h0};
    if (za || zb) return {s, 31'h0};
    ma = {40'h0, 1'b1, a[22:0]};
    mb = {40'h0, 1'b1, b[22:0]};
    p  = ma * mb;
    e  = ea + eb - 127;
    if (p >= (64'd1 << 47)) begin sh = 24; e++; end
    else sh = 23;
    mant = (p >> sh) & 64'h7FFFFF;
`ifdef FLOAT_MUL_RNE_EN
    rem  = p & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && mant[0])) mant++;
`endif
    if (mant == 64'h800000) begin mant = 0; e++; end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0)   return {s, 31'h0};
    return {s, e[7:0], mant[22:0]};
  endfunction

  // Cycle-age tracker: -1 idle, 0 = edge of acceptance, 27 = DONE cycle
  int          age = -1;
  bit          armed = 1'b0;
  logic [31:0] exp_res  = 32'h0;
  logic [31:0] exp_prod = 32'h0;

  always @(posedge clk) begin
    if (rst) begin
      age      = -1;
      exp_prod = 32'h0;
      armed    = 1'b1;
    end else if (age == -1) begin
      if (bus.start) begin
        age     = 0;
        exp_res = ref_mul(bus.X, bus.Y);
      end
    end else if (age == 27) begin
      age = -1;
    end else begin
      age++;
      if (age == 27) exp_prod = exp_res;
    end
  end

  // Per-cycle compare, away from the active edge
  always @(negedge clk) begin
    if (armed) begin
      check32("valid", {31'h0, bus.valid}, {31'h0, (age == 27)});
      if (age != 0)
        check32("busy", {31'h0, bus.busy}, {31'h0, (age >= 1 && age <= 26)});
      check32("product", bus.product, exp_prod);
    end
  end

  // One operation: optional start poke at a given edge count while busy
  task automatic run_op(input string name, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] expv, input int poke);
    int  lat;
    bit  seen;
    check32({name, "_model"}, ref_mul(x, y), expv);
    @(negedge clk);
    bus.X = x; bus.Y = y; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      if (bus.valid) seen = 1'b1;
      else begin
        lat++;
        if (lat == poke) begin
          bus.start = 1'b1; bus.X = 32'h40400000; bus.Y = 32'h40400000;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    if (!seen) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got no valid expected valid within 40 cycles", name);
    end else begin
      check_int({name, "_latency"}, lat, 27);
      check32({name, "_result"}, bus.product, expv);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.X     = 32'h0;
    bus.Y     = 32'h0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    check32("reset_product", bus.product, 32'h0);
    check32("reset_valid", {31'h0, bus.valid}, 32'h0);
    check32("reset_busy", {31'h0, bus.busy}, 32'h0);
    rst = 1'b0;

    run_op("mixed_sign", 32'h40700000, 32'hC0D80000, 32'hC1CA8000, 0);
    run_op("one5_x_two", 32'h3FC00000, 32'h40000000, 32'h40400000, 10);
    run_op("back2back", 32'h40000000, 32'h40000000, 32'h40800000, 0);
`ifdef FLOAT_MUL_RNE_EN
    run_op("round", 32'h3FC00001, 32'h3FC00001, 32'h40100002, 0);
`else
    run_op("round", 32'h3FC00001, 32'h3FC00001, 32'h40100001, 0);
`endif
    run_op("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 0);
    run_op("neg_inf", 32'hFF800000, 32'h40000000, 32'hFF800000, 0);
    run_op("neg_zero", 32'h80000000, 32'h40000000, 32'h80000000, 0);
    run_op("overflow", 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 0);
    run_op("underflow", 32'h00800000, 32'h3F000000, 32'h00000000, 0);
    run_op("nan_in", 32'h7FC00123, 32'h3F800000, 32'h7FC00000, 0);

    // Reset ten cycles into an operation: it must be abandoned silently
    begin
      bit seen_v;
      @(negedge clk);
      bus.X = 32'h40700000; bus.Y = 32'hC0D80000; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      seen_v = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (bus.valid) seen_v = 1'b1;
      end
      check32("abort_no_valid", {31'h0, seen_v}, 32'h0);
      check32("abort_product", bus.product, 32'h0);
    end
    run_op("after_abort", 32'h3FC00000, 32'h40000000, 32'h40400000, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/float_mul.md
Name: float_mul

Overview:
- Multi-cycle IEEE-754 single-precision multiplier. It is the stage directly upstream of the float adder in the activation datapath: it forms the product w*x, and the adder consumes that product as an operand.
- Uses the same start/valid handshake as the adder, so its product and valid can drive the adder's X/Y and start directly.
- Mantissa product is computed by an iterative shift-add over 24 cycles, so area stays small.
- Latency is fixed regardless of operand values.

Parameters:
- MANT_W, 24, mantissa width including the hidden bit; sets the iteration count. Only 24 is supported.
- BIAS, 127, exponent bias.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; X/Y are sampled on the edge where start=1 and the block is idle.
- X  input  32  operand A, IEEE-754 single.
- Y  input  32  operand B, IEEE-754 single.
- busy  output  1  high from the edge after start is accepted until the cycle before valid.
- valid  output  1  one-cycle pulse; product is valid that cycle.
- product  output  32  result; held until the next result is written.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, valid=0, busy=0, product=32'h0, counter=0, internal registers cleared. Reset mid-operation aborts the operation; no valid is produced.
- FSM states: IDLE, UNPACK, MULT, NORM, ROUND, DONE.
- IDLE:
  - start=1 latches X and Y, then goes to UNPACK.
  - start is ignored in every other state; no queuing.
- UNPACK:
  - sign = Xs ^ Ys.
  - Exponent fields of 0 are treated as zero (denormals flushed).
  - Sets hidden bit = 1 for normal operands.
  - Computes e = Ex + Ey - BIAS in a 10-bit signed register.
  - Classifies special cases.
  - Goes to MULT with counter=0.
- MULT:
  - 24 iterations of shift-add into a 48-bit accumulator, one multiplier bit (LSB first) per cycle.
  - Leaves to NORM when counter==23.
- NORM:
  - If acc[47]=1: take mantissa from acc[46:24], guard=acc[23], sticky=|acc[22:0], e=e+1.
  - Else: mantissa=acc[45:23], guard=acc[22], sticky=|acc[21:0].
- ROUND:
  - Apply rounding mode (see Optional Feature).
  - A carry out of the mantissa gives mantissa=0, e=e+1.
  - Then resolve the result and go to DONE.
- DONE:
  - product registered, valid=1 for exactly this cycle.
  - Next state is IDLE. start is accepted again in the IDLE cycle after DONE.
- Latency: valid is high in the cycle following the 27th rising edge after the edge that accepted start (1 UNPACK + 24 MULT + NORM + ROUND). This holds for all inputs, including special cases.
- Result priority, evaluated in ROUND:
  1. Either operand NaN, or Inf*0: 32'h7FC00000.
  2. Either operand Inf: {sign, 8'hFF, 23'h0}.
  3. Either operand zero: {sign, 31'h0}.
  4. Final e >= 255: {sign, 8'hFF, 23'h0} (overflow).
  5. Final e <= 0: {sign, 31'h0} (underflow, flush to zero).
  6. Otherwise: {sign, e[7:0], mantissa}.
- Back-to-back: the fastest throughput is one result per 29 cycles (start accepted in the IDLE cycle directly after DONE).

Optional Feature:
- Macro: FLOAT_MUL_RNE_EN.
- Defined: round to nearest even. The mantissa is incremented when guard & (sticky | mantissa[0]).
- Undefined: truncation. Guard and sticky are ignored, and the ROUND state still occupies one cycle so latency is identical.

Test Plan:
- rst=1 for 2 cycles, then release: product=0, valid=0, busy=0. X=32'h40700000 (3.75), Y=32'hC0D80000 (-6.75), start pulse -> busy high, valid pulse exactly 27 edges later, product=32'hC1CA8000 (-25.3125).
- X=32'h3FC00000 (1.5), Y=32'h40000000 (2.0) -> 32'h40400000. Then a second start in the IDLE cycle after DONE, with X=32'h40000000, Y=32'h40000000 -> 32'h40800000. Also pulse start during MULT and confirm it has no effect.
- X=32'h3FC00001, Y=32'h3FC00001:
  - FLOAT_MUL_RNE_EN defined -> 32'h40100002.
  - FLOAT_MUL_RNE_EN undefined -> 32'h40100001.
- Special cases:
  - X=32'h7F800000, Y=32'h00000000 -> 32'h7FC00000.
  - X=32'hFF800000, Y=32'h40000000 -> 32'hFF800000.
  - X=32'h80000000, Y=32'h40000000 -> 32'h80000000.
- Range limits:
  - X=32'h7F7FFFFF, Y=32'h40000000 -> 32'h7F800000 (overflow).
  - X=32'h00800000, Y=32'h3F000000 -> 32'h00000000 (underflow).
- Reset mid-operation: assert rst 10 cycles after start -> no valid ever appears, product=0. Then a new operation 1.5*2.0 -> 32'h40400000 with the normal latency.
